// File: rtl/tmds_pkg.sv
// Shared TMDS types and constants: mux select encoding, period state,
// the four control-period tokens and the video guard-band codes.
package tmds_pkg;

    typedef enum logic [1:0] {
        SEL_CTRL  = 2'b00,
        SEL_GUARD = 2'b01,
        SEL_VIDEO = 2'b10
    } sel_t;

    typedef enum logic [1:0] {
        ST_CTRL     = 2'b00,
        ST_PREAMBLE = 2'b01,
        ST_GUARD    = 2'b10,
        ST_VIDEO    = 2'b11
    } state_t;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    localparam logic [9:0] GUARD_CH02 = 10'b1011001100;
    localparam logic [9:0] GUARD_CH1  = 10'b0100110011;

    // Control token for {C1,C0}
    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] tok;
        unique case (c)
            2'b00:   tok = CTRL_TOKEN_00;
            2'b01:   tok = CTRL_TOKEN_01;
            2'b10:   tok = CTRL_TOKEN_10;
            default: tok = CTRL_TOKEN_11;
        endcase
        return tok;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Horizontal/vertical raster counters with window decodes.
// Ports:
//   clk, n_rst      pixel clock, async active-low reset
//   en_i            run enable; low clears both counters on the next edge
//   pre_c_o         current count is in the preamble window of an active line
//   guard_c_o       current count is in the guard window of an active line
//   video_c_o       current count is in the active video window
//   video_next_c_o  count after the next edge is in the active video window
//   hsync_c_o       current count is in the hsync window
//   vsync_c_o       current line is a vsync line
//   frame_c_o       current count is h=0, v=0
module raster_counter #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en_i,
    output logic pre_c_o,
    output logic guard_c_o,
    output logic video_c_o,
    output logic video_next_c_o,
    output logic hsync_c_o,
    output logic vsync_c_o,
    output logic frame_c_o
);

    localparam int unsigned H_TOTAL = H_BP + H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    // Signed compare keeps windows starting at zero free of always-true tests
    function automatic logic in_range(input int x, input int lo, input int hi);
        return (x >= lo) && (x <= hi);
    endfunction

    function automatic logic is_video(input logic [HW-1:0] h, input logic [VW-1:0] v);
        return in_range(int'(v), 0, int'(V_ACTIVE) - 1) &&
               in_range(int'(h), int'(H_BP), int'(H_BP + H_ACTIVE) - 1);
    endfunction

    // Next count: line wrap advances the line counter, en low clears both
    always_comb begin
        h_d = '0;
        v_d = '0;
        if (en_i) begin
            if (h_q == HW'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
                v_d = v_q;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    logic active_line;
    assign active_line = in_range(int'(v_q), 0, int'(V_ACTIVE) - 1);

    assign pre_c_o        = active_line && in_range(int'(h_q), int'(H_BP) - 10, int'(H_BP) - 3);
    assign guard_c_o      = active_line && in_range(int'(h_q), int'(H_BP) - 2, int'(H_BP) - 1);
    assign video_c_o      = is_video(h_q, v_q);
    assign video_next_c_o = is_video(h_d, v_d);
    assign hsync_c_o      = in_range(int'(h_q), int'(H_TOTAL - H_SYNC), int'(H_TOTAL) - 1);
    assign vsync_c_o      = in_range(int'(v_q), int'(V_ACTIVE + V_FP), int'(V_ACTIVE + V_FP + V_SYNC) - 1);
    assign frame_c_o      = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/tmds_period_ctrl.sv
// Per-channel TMDS period sequencer: classifies each pixel clock as
// control / preamble / guard / video and drives the output mux controls.
// Ports:
//   clk, n_rst   pixel clock, async active-low reset
//   en           run enable; low clears the raster and forces reset outputs
//   sel          mux select (00 control, 01 guard, 10 video)
//   blank_data   control token for this channel
//   guard_data   guard-band code for this channel
//   hsync/vsync  physical sync levels
//   de           data enable, high exactly when sel=10
//   pixel_req    high one cycle ahead of each de-high cycle
//   frame_start  one-cycle pulse for raster position h=0, v=0
module tmds_period_ctrl
    import tmds_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned CHANNEL  = 0
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       en,
    output logic [1:0] sel,
    output logic [9:0] blank_data,
    output logic [9:0] guard_data,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       pixel_req,
    output logic       frame_start
);

    localparam logic [9:0] GUARD_VAL = (CHANNEL == 1) ? GUARD_CH1 : GUARD_CH02;
    localparam logic [9:0] BLANK_RST = (CHANNEL == 0) ? ctrl_token({~VS_POL, ~HS_POL})
                                                      : CTRL_TOKEN_00;

    logic pre_c, guard_c, video_c, video_next_c, hsync_c, vsync_c, frame_c;

    raster_counter #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_raster (
        .clk            (clk),
        .n_rst          (n_rst),
        .en_i           (en),
        .pre_c_o        (pre_c),
        .guard_c_o      (guard_c),
        .video_c_o      (video_c),
        .video_next_c_o (video_next_c),
        .hsync_c_o      (hsync_c),
        .vsync_c_o      (vsync_c),
        .frame_c_o      (frame_c)
    );

    state_t     state_q, state_d;
    sel_t       sel_q, sel_d;
    logic [9:0] blank_q, blank_d;
    logic [9:0] guard_q;
    logic       hs_q, hs_d, vs_q, vs_d;
    logic       de_q, de_d, preq_q, preq_d, fs_q, fs_d;

    // Period state advances CTRL->PREAMBLE->GUARD->VIDEO->CTRL, falling back
    // to CTRL whenever the raster leaves the current window
    always_comb begin
        state_d = ST_CTRL;
        sel_d   = SEL_CTRL;
        hs_d    = ~HS_POL;
        vs_d    = ~VS_POL;
        preq_d  = 1'b0;
        fs_d    = 1'b0;
        blank_d = CTRL_TOKEN_00;
        if (en) begin
            unique case (state_q)
                ST_CTRL:     state_d = pre_c ? ST_PREAMBLE : ST_CTRL;
                ST_PREAMBLE: state_d = pre_c ? ST_PREAMBLE : (guard_c ? ST_GUARD : ST_CTRL);
                ST_GUARD:    state_d = guard_c ? ST_GUARD : (video_c ? ST_VIDEO : ST_CTRL);
                default:     state_d = video_c ? ST_VIDEO : ST_CTRL;
            endcase
            hs_d   = hsync_c ? HS_POL : ~HS_POL;
            vs_d   = vsync_c ? VS_POL : ~VS_POL;
            preq_d = video_next_c;
            fs_d   = frame_c;
        end
        unique case (state_d)
            ST_GUARD: sel_d = SEL_GUARD;
            ST_VIDEO: sel_d = SEL_VIDEO;
            default:  sel_d = SEL_CTRL;
        endcase
        de_d = (state_d == ST_VIDEO);
        // Token source: ch0 carries syncs, ch1 flags the video preamble
        if (CHANNEL == 0) begin
            blank_d = ctrl_token({vs_d, hs_d});
        end else if (CHANNEL == 1) begin
            blank_d = ctrl_token({1'b0, state_d == ST_PREAMBLE});
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_CTRL;
            sel_q   <= SEL_CTRL;
            blank_q <= BLANK_RST;
            guard_q <= GUARD_VAL;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            de_q    <= 1'b0;
            preq_q  <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            blank_q <= blank_d;
            guard_q <= GUARD_VAL;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            preq_q  <= preq_d;
            fs_q    <= fs_d;
        end
    end

    assign sel         = sel_q;
    assign blank_data  = blank_q;
    assign guard_data  = guard_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign de          = de_q;
    assign pixel_req   = preq_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_tmds_period_ctrl.sv
// Bench for tmds_period_ctrl: four instances (default timing ch0/ch1, tiny
// timing ch0, tiny timing ch2 with inverted sync polarity) compared against
// a raster-position model derived from the timing rules.
module tb_tmds_period_ctrl;

    logic clk   = 1'b0;
    logic n_rst = 1'b1;
    logic en    = 1'b1;

    always #5 clk = ~clk;

    logic [1:0] sel_w   [4];
    logic [9:0] blank_w [4];
    logic [9:0] guard_w [4];
    logic       hs_w [4], vs_w [4], de_w [4], pr_w [4], fs_w [4];
    logic [26:0] obs [4];

    always_comb begin
        for (int d = 0; d < 4; d++)
            obs[d] = {sel_w[d], de_w[d], pr_w[d], fs_w[d], hs_w[d], vs_w[d], blank_w[d], guard_w[d]};
    end

    tmds_period_ctrl #(.CHANNEL(0)) dut0 (
        .clk(clk), .n_rst(n_rst), .en(en), .sel(sel_w[0]), .blank_data(blank_w[0]),
        .guard_data(guard_w[0]), .hsync(hs_w[0]), .vsync(vs_w[0]), .de(de_w[0]),
        .pixel_req(pr_w[0]), .frame_start(fs_w[0]));

    tmds_period_ctrl #(.CHANNEL(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .en(en), .sel(sel_w[1]), .blank_data(blank_w[1]),
        .guard_data(guard_w[1]), .hsync(hs_w[1]), .vsync(vs_w[1]), .de(de_w[1]),
        .pixel_req(pr_w[1]), .frame_start(fs_w[1]));

    tmds_period_ctrl #(.H_ACTIVE(4), .H_FP(2), .H_SYNC(2), .H_BP(10), .V_ACTIVE(2),
                       .V_FP(1), .V_SYNC(1), .V_BP(1), .CHANNEL(0)) dut2 (
        .clk(clk), .n_rst(n_rst), .en(en), .sel(sel_w[2]), .blank_data(blank_w[2]),
        .guard_data(guard_w[2]), .hsync(hs_w[2]), .vsync(vs_w[2]), .de(de_w[2]),
        .pixel_req(pr_w[2]), .frame_start(fs_w[2]));

    tmds_period_ctrl #(.H_ACTIVE(4), .H_FP(2), .H_SYNC(2), .H_BP(10), .V_ACTIVE(2),
                       .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1),
                       .CHANNEL(2)) dut3 (
        .clk(clk), .n_rst(n_rst), .en(en), .sel(sel_w[3]), .blank_data(blank_w[3]),
        .guard_data(guard_w[3]), .hsync(hs_w[3]), .vsync(vs_w[3]), .de(de_w[3]),
        .pixel_req(pr_w[3]), .frame_start(fs_w[3]));

    int total = 0;
    int bad   = 0;

    // Model position: number of enabled edges since the last clear
    int m_cnt = 0;
    int m_pos = 0;
    bit m_rst = 1'b1;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_cnt <= 0;
            m_pos <= 0;
            m_rst <= 1'b1;
        end else if (!en) begin
            m_cnt <= 0;
            m_rst <= 1'b1;
        end else begin
            m_pos <= m_cnt;
            m_cnt <= m_cnt + 1;
            m_rst <= 1'b0;
        end
    end

    typedef struct {
        int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, ch;
        bit hp, vp;
    } cfg_t;

    function automatic cfg_t cfg_of(input int d);
        cfg_t c;
        if (d < 2) c = '{640, 16, 96, 48, 480, 10, 2, 33, d, 1'b0, 1'b0};
        else       c = '{4, 2, 2, 10, 2, 1, 1, 1, (d == 2) ? 0 : 2, (d == 3), (d == 3)};
        return c;
    endfunction

    function automatic logic [9:0] token(input logic [1:0] cc);
        case (cc)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    // Expected {sel,de,pixel_req,frame_start,hsync,vsync,blank,guard} for a raster position
    function automatic logic [26:0] model(input int d, input bit rst, input int p);
        cfg_t c;
        int ht, vt, q, h, v, q1, h1, v1;
        bit vid, grd, pre, preq, fs, hs_on, vs_on;
        logic hs, vs;
        logic [1:0] s, cc;
        logic [9:0] gd;
        c  = cfg_of(d);
        ht = c.hbp + c.ha + c.hfp + c.hsw;
        vt = c.va + c.vfp + c.vsw + c.vbp;
        q  = p % (ht * vt);      h  = q % ht;  v  = q / ht;
        q1 = (p + 1) % (ht * vt); h1 = q1 % ht; v1 = q1 / ht;
        vid   = !rst && v < c.va && h >= c.hbp && h < c.hbp + c.ha;
        grd   = !rst && v < c.va && h >= c.hbp - 2 && h < c.hbp;
        pre   = !rst && v < c.va && h >= c.hbp - 10 && h < c.hbp - 2;
        preq  = !rst && v1 < c.va && h1 >= c.hbp && h1 < c.hbp + c.ha;
        fs    = !rst && q == 0;
        hs_on = !rst && h >= ht - c.hsw;
        vs_on = !rst && v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw;
        hs = hs_on ? c.hp : !c.hp;
        vs = vs_on ? c.vp : !c.vp;
        s  = vid ? 2'b10 : (grd ? 2'b01 : 2'b00);
        if (c.ch == 0)      cc = {vs, hs};
        else if (c.ch == 1) cc = {1'b0, pre};
        else                cc = 2'b00;
        gd = (c.ch == 1) ? 10'b0100110011 : 10'b1011001100;
        return {s, vid, preq, fs, hs, vs, token(cc), gd};
    endfunction

    task automatic test_reset();
        logic [26:0] e;
        #1 n_rst = 1'b0;
        en = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            e = model(d, m_rst, m_pos);
            total++;
            if (obs[d] !== e) begin
                bad++;
                $display("FAIL reset dut%0d got=%b exp=%b", d, obs[d], e);
            end
        end
        total++;
        if ({sel_w[0], hs_w[0], vs_w[0], de_w[0]} !== 5'b00110) begin
            bad++;
            $display("FAIL reset_ch0_ctl got=%b exp=00110", {sel_w[0], hs_w[0], vs_w[0], de_w[0]});
        end
        total++;
        if (blank_w[0] !== 10'b1010101011) begin
            bad++;
            $display("FAIL reset_ch0_blank got=%b exp=1010101011", blank_w[0]);
        end
        n_rst = 1'b1;
        @(negedge clk);
        total++;
        if (fs_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL first_frame_start got=%b exp=1", fs_w[0]);
        end
        for (int d = 0; d < 4; d++) begin
            e = model(d, m_rst, m_pos);
            total++;
            if (obs[d] !== e) begin
                bad++;
                $display("FAIL reset_release dut%0d got=%b exp=%b", d, obs[d], e);
            end
        end
    endtask

    task automatic test_line_sequence();
        logic [26:0] e;
        int n_de = 0, n_pr = 0, n_pre = 0, n_grd = 0, n_hs = 0;
        @(negedge clk); en = 1'b0;
        @(negedge clk); en = 1'b1;
        for (int i = 0; i < 1600; i++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                e = model(d, m_rst, m_pos);
                total++;
                if (obs[d] !== e) begin
                    bad++;
                    $display("FAIL line dut%0d pos=%0d got=%b exp=%b", d, m_pos, obs[d], e);
                end
            end
            if (i < 800) begin
                if (de_w[1] === 1'b1 && sel_w[1] === 2'b10) n_de++;
                if (pr_w[1] === 1'b1) n_pr++;
                if (sel_w[1] === 2'b00 && blank_w[1] === 10'b0010101011) n_pre++;
                if (sel_w[1] === 2'b01 && guard_w[1] === 10'b0100110011) n_grd++;
                if (hs_w[0] === 1'b0) n_hs++;
            end
        end
        total++;
        if (n_de != 640) begin bad++; $display("FAIL de_count got=%0d exp=640", n_de); end
        total++;
        if (n_pr != 640) begin bad++; $display("FAIL preq_count got=%0d exp=640", n_pr); end
        total++;
        if (n_pre != 8) begin bad++; $display("FAIL preamble_count got=%0d exp=8", n_pre); end
        total++;
        if (n_grd != 2) begin bad++; $display("FAIL guard_count got=%0d exp=2", n_grd); end
        total++;
        if (n_hs != 96) begin bad++; $display("FAIL hsync_count got=%0d exp=96", n_hs); end
    endtask

    task automatic test_vblank_tiny();
        logic [26:0] e;
        int n_vs = 0, n_de = 0, n_fs = 0, n_hs = 0;
        @(negedge clk); en = 1'b0;
        @(negedge clk); en = 1'b1;
        for (int i = 0; i < 180; i++) begin
            @(negedge clk);
            for (int d = 2; d < 4; d++) begin
                e = model(d, m_rst, m_pos);
                total++;
                if (obs[d] !== e) begin
                    bad++;
                    $display("FAIL vblank dut%0d pos=%0d got=%b exp=%b", d, m_pos, obs[d], e);
                end
            end
            if (vs_w[2] === 1'b0) n_vs++;
            if (de_w[2] === 1'b1) n_de++;
            if (fs_w[2] === 1'b1) n_fs++;
            if (hs_w[2] === 1'b0) n_hs++;
        end
        total++;
        if (n_vs != 36) begin bad++; $display("FAIL tiny_vsync got=%0d exp=36", n_vs); end
        total++;
        if (n_de != 16) begin bad++; $display("FAIL tiny_de got=%0d exp=16", n_de); end
        total++;
        if (n_fs != 2) begin bad++; $display("FAIL tiny_frames got=%0d exp=2", n_fs); end
        total++;
        if (n_hs != 20) begin bad++; $display("FAIL tiny_hsync got=%0d exp=20", n_hs); end
    endtask

    task automatic test_en_drop();
        logic [26:0] e;
        @(negedge clk); en = 1'b0;
        @(negedge clk); en = 1'b1;
        repeat (300) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        total++;
        if ({sel_w[0], de_w[0], hs_w[0], vs_w[0], fs_w[0], pr_w[0]} !== 7'b0001100) begin
            bad++;
            $display("FAIL en_drop_ch0 got=%b exp=0001100",
                     {sel_w[0], de_w[0], hs_w[0], vs_w[0], fs_w[0], pr_w[0]});
        end
        for (int d = 0; d < 4; d++) begin
            e = model(d, m_rst, m_pos);
            total++;
            if (obs[d] !== e) begin
                bad++;
                $display("FAIL en_drop dut%0d got=%b exp=%b", d, obs[d], e);
            end
        end
        repeat (4) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        total++;
        if (fs_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL en_resume_frame got=%b exp=1", fs_w[0]);
        end
        for (int i = 0; i < 60; i++) begin
            for (int d = 0; d < 4; d++) begin
                e = model(d, m_rst, m_pos);
                total++;
                if (obs[d] !== e) begin
                    bad++;
                    $display("FAIL en_resume dut%0d pos=%0d got=%b exp=%b", d, m_pos, obs[d], e);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        logic [26:0] e;
        bit found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (de_w[1] === 1'b1) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL mid_reset_wait got=no_video exp=video_within_2000");
        end
        #1 n_rst = 1'b0;
        #1;
        total++;
        if ({sel_w[1], de_w[1]} !== 3'b000) begin
            bad++;
            $display("FAIL mid_reset_async got=%b exp=000", {sel_w[1], de_w[1]});
        end
        for (int d = 0; d < 4; d++) begin
            e = model(d, m_rst, m_pos);
            total++;
            if (obs[d] !== e) begin
                bad++;
                $display("FAIL mid_reset dut%0d got=%b exp=%b", d, obs[d], e);
            end
        end
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                e = model(d, m_rst, m_pos);
                total++;
                if (obs[d] !== e) begin
                    bad++;
                    $display("FAIL post_reset dut%0d pos=%0d got=%b exp=%b", d, m_pos, obs[d], e);
                end
            end
        end
    endtask

    task automatic test_random_en();
        logic [26:0] e;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                e = model(d, m_rst, m_pos);
                total++;
                if (obs[d] !== e) begin
                    bad++;
                    $display("FAIL random_en dut%0d pos=%0d rst=%0d got=%b exp=%b",
                             d, m_pos, m_rst, obs[d], e);
                end
            end
            en = ($urandom_range(0, 99) >= 3);
        end
        en = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_line_sequence();
        test_vblank_tiny();
        test_en_drop();
        test_mid_reset();
        test_random_en();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tmds_period_ctrl.md
Name: tmds_period_ctrl

Overview:
- Per-channel HDMI/DVI period sequencer. It sits directly upstream of the channel output mux and drives that mux's select, blanking-token and guard-band inputs.
- Runs the horizontal and vertical raster counters and classifies every pixel clock as control, preamble, video-guard or active video.
- Emits sync levels, data-enable and a one-cycle-early pixel request for the TMDS encoder.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch; must be >= 10
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- CHANNEL, 0, TMDS channel index, 0..2

Ports:
- clk  in  1  pixel clock
- n_rst  in  1  asynchronous active-low reset
- en  in  1  run enable; low = synchronous counter clear
- sel  out  2  mux select: 00 control, 01 guard, 10 video (11 never driven)
- blank_data  out  10  control token for this channel
- guard_data  out  10  video guard-band code for this channel
- hsync  out  1  physical hsync level
- vsync  out  1  physical vsync level
- de  out  1  high exactly when sel=10
- pixel_req  out  1  high one cycle before each de-high cycle
- frame_start  out  1  one-cycle pulse when h_cnt=0 and v_cnt=0

Behaviour:
- H_TOTAL = H_BP+H_ACTIVE+H_FP+H_SYNC.
- h_cnt runs 0..H_TOTAL-1 in this order: back porch [0,H_BP-1], active [H_BP,H_BP+H_ACTIVE-1], front porch, then sync (last H_SYNC counts).
- v_cnt increments when h_cnt wraps. Order: active [0,V_ACTIVE-1], front porch, sync, back porch. v_cnt wraps at V_TOTAL-1 to 0.
- Counters are unsigned and sized by $clog2(TOTAL).
- Line classification (state, on active lines only; all other lines are CTRL throughout):
  - PREAMBLE: h_cnt in [H_BP-10, H_BP-3], 8 clocks.
  - GUARD: h_cnt in [H_BP-2, H_BP-1], 2 clocks.
  - VIDEO: active window.
  - CTRL: everything else.
- State is a registered 2-bit encoding. Legal transitions: CTRL->PREAMBLE->GUARD->VIDEO->CTRL.
- All outputs are registered and reflect the counter value from the previous clock, giving a fixed 1-cycle latency from counter to output.
- sel mapping: CTRL and PREAMBLE give 00, GUARD gives 01, VIDEO gives 10.
- hsync = HS_POL during the hsync window, else ~HS_POL. vsync = VS_POL during vsync lines, else ~VS_POL. The vsync edge aligns with the h_cnt wrap.
- Control token selected by {C1,C0}:
  - 00 -> 1101010100
  - 01 -> 0010101011
  - 10 -> 0101010100
  - 11 -> 1010101011
- Token source per channel:
  - CHANNEL 0: {C1,C0} = {vsync,hsync} at all times.
  - CHANNEL 1: {C1,C0} = 01 during PREAMBLE, 00 otherwise.
  - CHANNEL 2: {C1,C0} = 00 always.
- guard_data is constant: 1011001100 for channels 0 and 2, 0100110011 for channel 1.
- pixel_req is high when the next registered state is VIDEO.
- en low: counters clear to 0 on the next edge and all outputs take their reset values. en rising resumes from h_cnt=0, v_cnt=0, and frame_start fires 1 cycle later.
- Reset values (asynchronous, n_rst low): h_cnt=0, v_cnt=0, state=CTRL, sel=00, de=0, pixel_req=0, frame_start=0, hsync=~HS_POL, vsync=~VS_POL.
  - blank_data: token({~VS_POL,~HS_POL}) for CHANNEL 0, 1101010100 for channels 1 and 2.
  - guard_data: its constant.
- Reset asserted mid-line aborts immediately; there is no completion of the current line or frame.

Decomposition:
- Shared package tmds_pkg holds:
  - typedef sel_t (SEL_CTRL=00, SEL_GUARD=01, SEL_VIDEO=10)
  - the four CTRL_TOKEN_* constants
  - GUARD_CH02 and GUARD_CH1
  - a function ctrl_token(c[1:0]) returning the 10-bit token
- One sub-module, raster_counter, holds the h/v counters, wrap logic and window decodes. tmds_period_ctrl holds the state register and output registers.

Test Plan:
- Reset: hold n_rst=0 with defaults, CHANNEL=0 -> sel=00, hsync=1, vsync=1, blank_data=1010101011, de=0. Release; first frame_start pulse appears 1 cycle after the first clocked edge with en=1.
- Line sequence (defaults, CHANNEL=1), first line of the frame:
  - sel=00 for h_cnt 0..37; blank_data=1101010100.
  - sel=00 with blank_data=0010101011 for 8 cycles (h_cnt 38..45).
  - sel=01, guard_data=0100110011 for 2 cycles.
  - sel=10 with de=1 for exactly 640 cycles, then sel=00.
- pixel_req/de alignment: pixel_req rises exactly 1 cycle before de rises and falls 1 cycle before de falls, on every active line. Count 640 pixel_req-high cycles per line.
- Vertical blanking (defaults, CHANNEL=0):
  - lines 480..524: sel never leaves 00 and de stays 0.
  - vsync=0 for exactly 2×800 clocks starting at line 490.
  - during sync overlap blank_data=0010101011 (hs=1, vs=0 -> C=01) or 1101010100 (both 0) as appropriate.
  - frame period is 420000 clocks.
- Tiny override (H_ACTIVE=4, H_FP=2, H_SYNC=2, H_BP=10, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1): exact cycle-by-cycle sel trace matches the golden model over 2 frames.
- en drop and mid-line reset: en=0 at h_cnt=300 -> outputs at reset values next cycle, and frame restarts from 0 after en=1. Assert n_rst during sel=10 -> sel=00 and de=0 immediately, without waiting for a clock.
